reg_writeback_queue: RTL and testbench

//   Write-side front end for the 17-entry register bank (R0..R15, R16 = SP).

---
 rtl/reg_writeback_queue_if.sv | 35 +++
 rtl/reg_writeback_queue.sv | 97 +++++++++
 tb/tb_reg_writeback_queue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Bundles the write-request, bank-write, hazard-lookup and status signals
// of the register writeback queue.
interface reg_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              rf_grant;
    logic              write_enable;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] query_reg;
    logic              query_hit;
    logic [DATA_W-1:0] query_data;
    logic [CNT_W-1:0]  count;
    logic              bad_reg_err;

    modport master (
        output in_valid, in_reg, in_data, rf_grant, query_reg,
        input  in_ready, write_enable, write_reg, write_data,
               query_hit, query_data, count, bad_reg_err
    );

    modport slave (
        input  in_valid, in_reg, in_data, rf_grant, query_reg,
        output in_ready, write_enable, write_reg, write_data,
               query_hit, query_data, count, bad_reg_err
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// FIFO front end for the register bank write port, with a combinational
// pending-write lookup used by decode for hazards and forwarding.
module reg_writeback_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int MAX_REG = 16
) (
    input  logic clk,
    input  logic rst,
    reg_writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] MAX_REG_IDX = ADDR_W'(MAX_REG);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count_q;
    logic              we_q;
    logic [ADDR_W-1:0] wr_q;
    logic [DATA_W-1:0] wd_q;
    logic              bad_q;

    logic              in_ready;
    logic              push_fire;
    logic              store;
    logic              bad_req;
    logic              pop;

    // in_ready comes only from registered occupancy, so a same-cycle pop never frees a slot.
    assign in_ready  = (count_q != CNT_FULL);
    assign push_fire = bus.in_valid && in_ready;
    assign bad_req   = push_fire && (bus.in_reg > MAX_REG_IDX);
    assign store     = push_fire && (bus.in_reg != '0) && !(bus.in_reg > MAX_REG_IDX);
    assign pop       = bus.rf_grant && (count_q != '0);

    always_ff @(posedge clk) begin
        if (store) begin
            mem_reg[tail]  <= bus.in_reg;
            mem_data[tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            wd_q    <= '0;
            bad_q   <= 1'b0;
        end else begin
            if (store) tail <= tail + PTR_ONE;
            if (pop) begin
                head <= head + PTR_ONE;
                wr_q <= mem_reg[head];
                wd_q <= mem_data[head];
            end
            count_q <= count_q + CNT_W'(store) - CNT_W'(pop);
            we_q    <= pop;
            if (bad_req) bad_q <= 1'b1;
        end
    end

    // Walk oldest to youngest so the tail-most match wins; the output register is oldest of all.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx            = '0;
        bus.query_hit  = 1'b0;
        bus.query_data = '0;
        if (bus.query_reg != '0) begin
            if (we_q && (wr_q == bus.query_reg)) begin
                bus.query_hit  = 1'b1;
                bus.query_data = wd_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (mem_reg[idx] == bus.query_reg)) begin
                    bus.query_hit  = 1'b1;
                    bus.query_data = mem_data[idx];
                end
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.write_enable = we_q;
    assign bus.write_reg    = wr_q;
    assign bus.write_data   = wd_q;
    assign bus.count        = count_q;
    assign bus.bad_reg_err  = bad_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus
// randomized traffic checked against a queue-based reference model.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    entry_t      mq[$];
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_bad;

    reg_writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32), .MAX_REG(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        exp_we   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
        exp_bad  = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_step();
        entry_t e;
        bit ready;
        ready = (mq.size() < DEPTH);
        if (bus.rf_grant && mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = 1'b1;
            exp_reg = e.r;
            exp_data = e.d;
        end else begin
            exp_we = 1'b0;
        end
        if (bus.in_valid && ready) begin
            if (bus.in_reg > 5'd16) exp_bad = 1'b1;
            else if (bus.in_reg != 5'd0) begin
                e.r = bus.in_reg;
                e.d = bus.in_data;
                mq.push_back(e);
            end
        end
    endtask

    task automatic model_query(input logic [4:0] q, output logic hit, output logic [31:0] data);
        hit = 1'b0;
        data = '0;
        if (q != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].r == q) begin
                    hit = 1'b1;
                    data = mq[i].d;
                end
            end
            if (!hit && exp_we && exp_reg == q) begin
                hit = 1'b1;
                data = exp_data;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_reg = '0;
        bus.in_data = '0;
        bus.rf_grant = 1'b0;
        bus.query_reg = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_reg = r;
        bus.in_data = d;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", bus.write_enable); end
        if (bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wout: got %0d/%0h expected 0/0", bus.write_reg, bus.write_data); end
        if (bus.bad_reg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bad: got %b expected 0", bus.bad_reg_err); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.in_ready); end
        if (bus.query_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b expected 0", bus.query_hit); end
    endtask

    task automatic test_latency();
        bus.rf_grant = 1'b1;
        push(5'd5, 32'h1234);
        checks += 2;
        if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_we: got %b expected 0", bus.write_enable); end
        if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL lat_count1: got %0d expected 1", bus.count); end
        cycle();
        checks += 2;
        if (bus.write_enable !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'h1234) begin
            errors++; $display("[TB] FAIL lat_write: got we=%b reg=%0d data=%0h expected 1/5/1234", bus.write_enable, bus.write_reg, bus.write_data);
        end
        if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL lat_count0: got %0d expected 0", bus.count); end
        cycle();
        checks++;
        if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL lat_we_drop: got %b expected 0", bus.write_enable); end
    endtask

    task automatic test_stall_fill();
        bus.rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
        checks += 2;
        if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.count); end
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready: got %b expected 0", bus.in_ready); end
        push(5'd9, 32'h999);
        checks++;
        if (bus.count !== 3'd4 || bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL fifth_stall: got count=%0d we=%b expected 4/0", bus.count, bus.write_enable); end
        bus.rf_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checks++;
            if (bus.write_enable !== 1'b1 || bus.write_reg !== 5'(i) || bus.write_data !== 32'h100 + 32'(i)) begin
                errors++; $display("[TB] FAIL drain_order: got we=%b reg=%0d data=%0h expected 1/%0d/%0h", bus.write_enable, bus.write_reg, bus.write_data, i, 32'h100 + 32'(i));
            end
        end
        cycle();
        checks++;
        if (bus.write_enable !== 1'b0 || bus.write_reg !== 5'd4) begin errors++; $display("[TB] FAIL drain_hold: got we=%b reg=%0d expected 0/4", bus.write_enable, bus.write_reg); end
    endtask

    task automatic test_filter();
        bus.rf_grant = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL r0_ready: got %b expected 1", bus.in_ready); end
        push(5'd0, 32'hFFFF);
        checks++;
        if (bus.count !== 3'd0 || bus.bad_reg_err !== 1'b0) begin errors++; $display("[TB] FAIL r0_drop: got count=%0d bad=%b expected 0/0", bus.count, bus.bad_reg_err); end
        push(5'd20, 32'h1);
        cycle();
        cycle();
        checks += 2;
        if (bus.bad_reg_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_sticky: got %b expected 1", bus.bad_reg_err); end
        if (bus.count !== 3'd0 || bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL bad_drop: got count=%0d we=%b expected 0/0", bus.count, bus.write_enable); end
        apply_reset();
        checks++;
        if (bus.bad_reg_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_clear: got %b expected 0", bus.bad_reg_err); end
    endtask

    task automatic test_forward();
        bus.rf_grant = 1'b0;
        push(5'd16, 32'hA);
        push(5'd16, 32'hB);
        bus.query_reg = 5'd16;
        #1;
        checks++;
        if (bus.query_hit !== 1'b1 || bus.query_data !== 32'hB) begin errors++; $display("[TB] FAIL fwd_young: got hit=%b data=%0h expected 1/b", bus.query_hit, bus.query_data); end
        bus.query_reg = 5'd7;
        #1;
        checks++;
        if (bus.query_hit !== 1'b0 || bus.query_data !== 32'h0) begin errors++; $display("[TB] FAIL fwd_miss: got hit=%b data=%0h expected 0/0", bus.query_hit, bus.query_data); end
        bus.query_reg = 5'd16;
        bus.rf_grant = 1'b1;
        cycle();
        checks++;
        if (bus.query_hit !== 1'b1 || bus.query_data !== 32'hB) begin errors++; $display("[TB] FAIL fwd_mid: got hit=%b data=%0h expected 1/b", bus.query_hit, bus.query_data); end
        cycle();
        checks++;
        if (bus.query_hit !== 1'b1 || bus.query_data !== 32'hB) begin errors++; $display("[TB] FAIL fwd_outreg: got hit=%b data=%0h expected 1/b", bus.query_hit, bus.query_data); end
        cycle();
        checks++;
        if (bus.query_hit !== 1'b0 || bus.query_data !== 32'h0) begin errors++; $display("[TB] FAIL fwd_gone: got hit=%b data=%0h expected 0/0", bus.query_hit, bus.query_data); end
        bus.query_reg = 5'd0;
    endtask

    task automatic test_async_reset();
        bus.rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i + 8), 32'hC0 + 32'(i));
        bus.rf_grant = 1'b1;
        cycle();
        checks++;
        if (bus.count !== 3'd3 || bus.write_enable !== 1'b1) begin errors++; $display("[TB] FAIL mid_drain: got count=%0d we=%b expected 3/1", bus.count, bus.write_enable); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.count !== 3'd0 || bus.write_enable !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
            errors++; $display("[TB] FAIL async_clear: got count=%0d we=%b reg=%0d data=%0h expected all 0", bus.count, bus.write_enable, bus.write_reg, bus.write_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (bus.write_enable !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_we: got %b expected 0", bus.write_enable); end
        end
    endtask

    task automatic test_full_steady();
        bus.rf_grant = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(5'($urandom_range(1, 16)), $urandom);
        bus.rf_grant = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_reg = 5'($urandom_range(1, 16));
            bus.in_data = $urandom;
            cycle();
            checks += 2;
            if (bus.count > 3'd4 || bus.count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL full_count: got %0d expected %0d", bus.count, mq.size()); end
            if (bus.write_enable !== exp_we || (exp_we && (bus.write_reg !== exp_reg || bus.write_data !== exp_data))) begin
                errors++; $display("[TB] FAIL full_write: got %b/%0d/%0h expected %b/%0d/%0h", bus.write_enable, bus.write_reg, bus.write_data, exp_we, exp_reg, exp_data);
            end
        end
        bus.in_valid = 1'b0;
        bus.rf_grant = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
    endtask

    task automatic test_random();
        logic        hit;
        logic [31:0] data;
        for (int n = 0; n < 300; n++) begin
            bus.in_valid = ($urandom_range(0, 9) < 6);
            bus.in_reg = 5'($urandom_range(0, 40) == 0 ? $urandom_range(17, 31) : $urandom_range(0, 16));
            bus.in_data = $urandom;
            bus.rf_grant = ($urandom_range(0, 9) < 5);
            bus.query_reg = 5'($urandom_range(0, 16));
            #1;
            model_query(bus.query_reg, hit, data);
            checks += 2;
            if (bus.query_hit !== hit || bus.query_data !== data) begin errors++; $display("[TB] FAIL rnd_query: got %b/%0h expected %b/%0h", bus.query_hit, bus.query_data, hit, data); end
            if (bus.in_ready !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_ready: got %b expected %b", bus.in_ready, mq.size() < DEPTH); end
            cycle();
            checks += 3;
            if (bus.count !== 3'(mq.size())) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected %0d", bus.count, mq.size()); end
            if (bus.write_enable !== exp_we || bus.write_reg !== exp_reg || bus.write_data !== exp_data) begin
                errors++; $display("[TB] FAIL rnd_write: got %b/%0d/%0h expected %b/%0d/%0h", bus.write_enable, bus.write_reg, bus.write_data, exp_we, exp_reg, exp_data);
            end
            if (bus.bad_reg_err !== exp_bad) begin errors++; $display("[TB] FAIL rnd_bad: got %b expected %b", bus.bad_reg_err, exp_bad); end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_stall_fill();
        test_filter();
        test_forward();
        test_async_reset();
        test_full_steady();
        apply_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
